// File: rtl/tdc_meas_ctrl.sv
// Launch/capture sequencer for the edge-detector TDC: encodes and averages thermometer samples.
// Optional per-measurement min/max code outputs are enabled with `define TDC_MINMAX_EN.
module tdc_meas_ctrl #(
    parameter int NTAP       = 16,
    parameter int NSAMP_LOG2 = 2,
    parameter int SETTLE     = 2,
    parameter int CW         = $clog2(NTAP + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            launch_o,
    input  logic [NTAP:1]   edge_in_i,
    output logic [CW-1:0]   result_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic            err_o
`ifdef TDC_MINMAX_EN
    ,
    output logic [CW-1:0]   result_min_o,
    output logic [CW-1:0]   result_max_o
`endif
);

    localparam int AW = CW + NSAMP_LOG2;
    localparam int SW = NSAMP_LOG2;
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   acc_q;
    logic [SW-1:0]   samp_q;
    logic [WW-1:0]   wait_q;
    logic [CW-1:0]   code_d;
    logic            bubble_d;

    // Returns {bubble, code}: code counts the unbroken run of ones from tap 1,
    // bubble flags any one found after that run has ended.
    function automatic logic [CW:0] encode(input logic [NTAP:1] e);
        logic [CW-1:0] code;
        logic          run;
        logic          bub;
        code = '0;
        run  = 1'b1;
        bub  = 1'b0;
        for (int i = 1; i <= NTAP; i++) begin
            if (run) begin
                if (e[i]) code = code + CW'(1);
                else      run  = 1'b0;
            end else if (e[i]) begin
                bub = 1'b1;
            end
        end
        return {bub, code};
    endfunction

    always_comb begin
        {bubble_d, code_d} = encode(edge_in_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            busy_o         <= 1'b0;
            launch_o       <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            err_o          <= 1'b0;
            acc_q          <= '0;
            samp_q         <= '0;
            wait_q         <= '0;
`ifdef TDC_MINMAX_EN
            result_min_o   <= '0;
            result_max_o   <= '0;
`endif
        end else begin
            launch_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_LAUNCH;
                        busy_o       <= 1'b1;
                        launch_o     <= 1'b1;
                        acc_q        <= '0;
                        samp_q       <= '0;
                        err_o        <= 1'b0;
`ifdef TDC_MINMAX_EN
                        result_min_o <= CW'(NTAP);
                        result_max_o <= '0;
`endif
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT;
                    wait_q  <= WW'(SETTLE - 1);
                end
                S_WAIT: begin
                    if (wait_q == '0) state_q <= S_CAPTURE;
                    else              wait_q  <= wait_q - WW'(1);
                end
                S_CAPTURE: begin
                    acc_q  <= acc_q + AW'(code_d);
                    samp_q <= samp_q + SW'(1);
                    if (bubble_d) err_o <= 1'b1;
`ifdef TDC_MINMAX_EN
                    if (code_d < result_min_o) result_min_o <= code_d;
                    if (code_d > result_max_o) result_max_o <= code_d;
`endif
                    if (samp_q == '1) state_q <= S_DONE;
                    else              state_q <= S_GAP;
                end
                S_GAP: begin
                    // Launch held low one cycle so the delay path sees a falling edge.
                    state_q  <= S_LAUNCH;
                    launch_o <= 1'b1;
                end
                S_DONE: begin
                    if (!result_valid_o) begin
                        result_o       <= acc_q[AW-1:NSAMP_LOG2];
                        result_valid_o <= 1'b1;
                    end else if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
- Sequencer for the 16-tap edge-detector TDC in the CPM sensor.
- Issues launch pulses that feed the delay path into DELAY_IN, waits for the TDC capture, and samples the EDGE_OUT thermometer.
- Encodes each sample to a tap count, averages 2^NSAMP_LOG2 samples and returns the result over a valid/ready handshake.
- Flags thermometer bubbles that indicate metastability or a broken delay cell.

Parameters:
- NTAP, 16, number of TDC taps (EDGE_IN width).
- NSAMP_LOG2, 2, log2 of samples averaged per measurement (4 samples).
- SETTLE, 2, cycles in WAIT between LAUNCH and CAPTURE (≥1).
- CW, 5, code width, equal to clog2(NTAP+1).

Ports:
- CLK  input  1  system clock; same clock as the TDC capture flops.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request a measurement; sampled only in IDLE.
- BUSY  output  1  high in any state other than IDLE.
- LAUNCH  output  1  one-cycle launch pulse into the delay path / DELAY_IN source.
- EDGE_IN  input  NTAP  TDC EDGE_OUT; bit 1 is tap 1 (nearest DELAY_IN), indexed [1:NTAP].
- RESULT  output  CW  averaged tap code.
- RESULT_VALID  output  1  RESULT is valid.
- RESULT_READY  input  1  consumer accepts RESULT.
- ERR  output  1  bubble seen in at least one sample of this measurement; valid with RESULT_VALID.

Behaviour:
- Reset (asynchronous, RST=1): state IDLE; LAUNCH, BUSY, RESULT_VALID, ERR = 0; RESULT = 0; accumulator and counters = 0. Reset mid-measurement aborts it, with no partial result.
- States: IDLE, LAUNCH, WAIT, CAPTURE, GAP, DONE.
- IDLE: START=1 → LAUNCH; clear accumulator, sample counter and ERR.
- LAUNCH: LAUNCH=1 for exactly this cycle → WAIT; load wait counter with SETTLE-1.
- WAIT: decrement the counter; at 0 → CAPTURE.
- CAPTURE: register EDGE_IN and encode it.
  - code = number of consecutive 1s starting at tap 1. All zeros → 0; all ones → NTAP.
  - Bubble = any 1 at a tap beyond the first 0; it sets ERR (sticky until the next START). The code ignores taps after the first 0.
  - accumulator += code; accumulator width is CW+NSAMP_LOG2, so it cannot overflow.
  - If this is the last sample → DONE, else → GAP.
- GAP: one cycle with LAUNCH low, giving a guaranteed falling edge on the delay path → LAUNCH.
- DONE:
  - RESULT = accumulator >> NSAMP_LOG2 (truncating); RESULT_VALID=1.
  - RESULT and ERR are held stable until RESULT_VALID && RESULT_READY, then → IDLE and RESULT_VALID drops on the next edge.
  - RESULT retains its value in IDLE.
- START is ignored outside IDLE. START high in the same cycle as the DONE handshake is not accepted; the next measurement starts from IDLE.
- Latency: if START is sampled at edge 0, RESULT_VALID rises at edge 2^NSAMP_LOG2 × (SETTLE+3). With defaults, edge 20.
- LAUNCH pulses are spaced SETTLE+3 cycles apart.

Optional Feature:
- Macro TDC_MINMAX_EN.
- Defined:
  - Adds outputs RESULT_MIN and RESULT_MAX (CW each), tracking the minimum and maximum per-sample code of the measurement.
  - Both are valid and held with RESULT_VALID.
  - At START they initialise to min=NTAP, max=0; reset value is 0.
- Undefined: no ports, no logic; behaviour otherwise identical.

Test Plan:
- Reset during WAIT of sample 2: RST pulse → LAUNCH/BUSY/RESULT_VALID drop immediately and state returns to IDLE. START afterwards yields a full 4-sample measurement.
- Basic averaging: START, EDGE_IN taps 1–6 high for samples 1–2 and taps 1–7 high for samples 3–4 → RESULT_VALID at edge 20, RESULT=6, ERR=0. Exactly 4 LAUNCH pulses, 5 cycles apart.
- Boundary codes: all-zero EDGE_IN for all samples → RESULT=0. All-ones → RESULT=16.
- Bubble: taps 1–3 high, tap 4 low, tap 5 high in sample 2 only, else taps 1–3 → per-sample code 3, RESULT=3, ERR=1.
- Handshake: RESULT_READY low for 10 cycles after RESULT_VALID → RESULT and ERR stable and START pulses ignored; READY high → IDLE next edge and BUSY=0.
- TDC_MINMAX_EN build: samples coded 4, 9, 6, 5 → RESULT=6, RESULT_MIN=4, RESULT_MAX=9.
